// File: rtl/riscv_writeback_pkg.sv
// Shared constants and types for the integer writeback path.
//   WORD_LENGTH / ADDR_LENGTH / NUM_REGS : datapath, register-address and scoreboard widths
//   rf_wen_e    : register-file write-enable encoding (RF_WRITE / RF_NO_WRITE)
//   wb_src_e    : which producer the arbiter picked this cycle
//   wb_result_t : destination + data payload carried from a producer to the RF
package riscv_writeback_pkg;

  localparam int unsigned WORD_LENGTH = 32;
  localparam int unsigned ADDR_LENGTH = 5;
  localparam int unsigned NUM_REGS    = 32;

  typedef enum logic {
    RF_NO_WRITE = 1'b0,
    RF_WRITE    = 1'b1
  } rf_wen_e;

  typedef enum logic {
    WB_SRC_ALU = 1'b0,
    WB_SRC_LSU = 1'b1
  } wb_src_e;

  typedef struct packed {
    logic [ADDR_LENGTH-1:0] rd;
    logic [WORD_LENGTH-1:0] data;
  } wb_result_t;

  // One-hot mask selecting register rd in the scoreboard bitmap.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [ADDR_LENGTH-1:0] rd);
    reg_onehot = NUM_REGS'(1) << rd;
  endfunction

endpackage

// File: rtl/riscv_writeback_if.sv
// Producer-to-writeback result handshake (ALU and LSU lanes).
//   master : producer side, drives valid/rd/data, observes ready
//   slave  : writeback side, observes valid/rd/data, drives ready
// A producer holds rd/data stable while valid is high until it sees ready.
interface riscv_writeback_if;
  import riscv_writeback_pkg::*;

  logic                   alu_valid;
  logic [ADDR_LENGTH-1:0] alu_rd;
  logic [WORD_LENGTH-1:0] alu_data;
  logic                   alu_ready;

  logic                   lsu_valid;
  logic [ADDR_LENGTH-1:0] lsu_rd;
  logic [WORD_LENGTH-1:0] lsu_data;
  logic                   lsu_ready;

  modport master (
    output alu_valid, alu_rd, alu_data,
    input  alu_ready,
    output lsu_valid, lsu_rd, lsu_data,
    input  lsu_ready
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    output alu_ready,
    input  lsu_valid, lsu_rd, lsu_data,
    output lsu_ready
  );

endinterface

// File: rtl/riscv_scoreboard.sv
// Pending-destination scoreboard for read-after-write hazard detection.
//   clk, rst_n          : clock, asynchronous active-low reset
//   set_en_i, set_rd_i  : decode issued a writer of set_rd_i
//   clr_en_i, clr_rd_i  : register file is committing clr_rd_i at this edge
//   flush_i             : drop every pending destination
//   rs1_i, rs2_i        : decode source operands to look up
//   hazard_c_o          : combinational, either source still has a writer in flight
//   pending_o           : registered bitmap of in-flight destinations
module riscv_scoreboard
  import riscv_writeback_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   set_en_i,
  input  logic [ADDR_LENGTH-1:0] set_rd_i,
  input  logic                   clr_en_i,
  input  logic [ADDR_LENGTH-1:0] clr_rd_i,
  input  logic                   flush_i,
  input  logic [ADDR_LENGTH-1:0] rs1_i,
  input  logic [ADDR_LENGTH-1:0] rs2_i,
  output logic                   hazard_c_o,
  output logic [NUM_REGS-1:0]    pending_o
);

  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] pending_d;

  // Clear first so a same-edge set (younger writer) wins; flush beats both; x0 never pends.
  always_comb begin
    pending_d = pending_q;
    if (clr_en_i) begin
      pending_d = pending_d & ~reg_onehot(clr_rd_i);
    end
    if (set_en_i && (set_rd_i != '0)) begin
      pending_d = pending_d | reg_onehot(set_rd_i);
    end
    if (flush_i) begin
      pending_d = '0;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  // Bit clears only at the commit edge, so decode stalls through the cycle the write is presented.
  assign hazard_c_o = pending_q[rs1_i] | pending_q[rs2_i];
  assign pending_o  = pending_q;

endmodule

// File: rtl/riscv_writeback.sv
// Integer register-file writeback: arbitrates ALU/LSU results to one write per cycle.
//   clk, rst_n                       : clock, asynchronous active-low reset
//   issue_valid, issue_rd            : decode issued a writer of issue_rd
//   prod (slave)                     : ALU and LSU result handshakes, LSU has fixed priority
//   flush                            : pipeline flush, blocks acceptance and clears the scoreboard
//   query_rs1, query_rs2, hazard     : combinational RAW lookup for decode
//   rf_write_en/addr/data            : registered register-file write port
//   pending                          : scoreboard bitmap
//   commit_count                     : committed writes, wraps at 2^32
module riscv_writeback
  import riscv_writeback_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   issue_valid,
  input  logic [ADDR_LENGTH-1:0] issue_rd,
  riscv_writeback_if.slave       prod,
  input  logic                   flush,
  input  logic [ADDR_LENGTH-1:0] query_rs1,
  input  logic [ADDR_LENGTH-1:0] query_rs2,
  output logic                   hazard,
  output rf_wen_e                rf_write_en,
  output logic [ADDR_LENGTH-1:0] rf_write_addr,
  output logic [WORD_LENGTH-1:0] rf_write_data,
  output logic [NUM_REGS-1:0]    pending,
  output logic [31:0]            commit_count
);

  logic       lsu_ready_c;
  logic       alu_ready_c;
  logic       accept_c;
  wb_src_e    src_c;
  wb_result_t sel_c;

  rf_wen_e    wen_q,   wen_d;
  wb_result_t wr_q,    wr_d;
  logic [31:0] count_q, count_d;

  // Fixed-priority arbitration; flush refuses both producers.
  always_comb begin
    lsu_ready_c = prod.lsu_valid && !flush;
    alu_ready_c = prod.alu_valid && !prod.lsu_valid && !flush;
    accept_c    = lsu_ready_c || alu_ready_c;
    src_c       = lsu_ready_c ? WB_SRC_LSU : WB_SRC_ALU;
  end

  assign prod.lsu_ready = lsu_ready_c;
  assign prod.alu_ready = alu_ready_c;

  // Payload mux driven by the source select.
  always_comb begin
    sel_c = '0;
    case (src_c)
      WB_SRC_LSU: begin
        sel_c.rd   = prod.lsu_rd;
        sel_c.data = prod.lsu_data;
      end
      default: begin
        sel_c.rd   = prod.alu_rd;
        sel_c.data = prod.alu_data;
      end
    endcase
  end

  // Output register: x0 results are consumed but never written; addr/data hold when idle.
  always_comb begin
    wen_d   = RF_NO_WRITE;
    wr_d    = wr_q;
    count_d = count_q + 32'(wen_q == RF_WRITE);
    if (accept_c) begin
      wr_d  = sel_c;
      wen_d = (sel_c.rd != '0) ? RF_WRITE : RF_NO_WRITE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wen_q   <= RF_NO_WRITE;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      wen_q   <= wen_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end

  riscv_scoreboard u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .set_en_i   (issue_valid),
    .set_rd_i   (issue_rd),
    .clr_en_i   (wen_q == RF_WRITE),
    .clr_rd_i   (wr_q.rd),
    .flush_i    (flush),
    .rs1_i      (query_rs1),
    .rs2_i      (query_rs2),
    .hazard_c_o (hazard),
    .pending_o  (pending)
  );

  assign rf_write_en   = wen_q;
  assign rf_write_addr = wr_q.rd;
  assign rf_write_data = wr_q.data;
  assign commit_count  = count_q;

endmodule

// File: tb/tb_riscv_writeback.sv
// Self-checking bench for riscv_writeback: directed scenarios then randomized traffic,
// with a per-edge expected-write queue checked by an independent monitor.
module tb_riscv_writeback;
  import riscv_writeback_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        flush;
  logic [4:0]  query_rs1;
  logic [4:0]  query_rs2;
  logic        hazard;
  rf_wen_e     rf_write_en;
  logic [4:0]  rf_write_addr;
  logic [31:0] rf_write_data;
  logic [31:0] pending;
  logic [31:0] commit_count;

  riscv_writeback_if wb_if ();

  riscv_writeback dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .issue_valid  (issue_valid),
    .issue_rd     (issue_rd),
    .prod         (wb_if),
    .flush        (flush),
    .query_rs1    (query_rs1),
    .query_rs2    (query_rs2),
    .hazard       (hazard),
    .rf_write_en  (rf_write_en),
    .rf_write_addr(rf_write_addr),
    .rf_write_data(rf_write_data),
    .pending      (pending),
    .commit_count (commit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          we;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: set of in-flight destinations, the write due at the next edge, commit total.
  bit          pend_m[32];
  bit          pres_v;
  logic [4:0]  pres_rd;
  int unsigned cnt_m;
  bit          alu_acc, lsu_acc;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pend_vec();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = pend_m[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) pend_m[i] = 1'b0;
    pres_v  = 1'b0;
    pres_rd = '0;
    cnt_m   = 0;
    alu_acc = 1'b0;
    lsu_acc = 1'b0;
    exp_q.delete();
  endtask

  task automatic idle();
    issue_valid     = 1'b0;
    issue_rd        = '0;
    flush           = 1'b0;
    wb_if.alu_valid = 1'b0;
    wb_if.lsu_valid = 1'b0;
  endtask

  // Entered at a negedge with inputs applied; checks combinational and state outputs,
  // advances the model across the posedge, and returns at the following negedge.
  task automatic cycle();
    bit         exp_lr, exp_ar, acc;
    logic [4:0] rd;
    logic [31:0] data;
    #1;
    exp_lr = wb_if.lsu_valid && !flush;
    exp_ar = wb_if.alu_valid && !wb_if.lsu_valid && !flush;
    chk("lsu_ready", 64'(wb_if.lsu_ready), 64'(exp_lr));
    chk("alu_ready", 64'(wb_if.alu_ready), 64'(exp_ar));
    chk("hazard", 64'(hazard), 64'(pend_m[query_rs1] | pend_m[query_rs2]));
    chk("pending", 64'(pending), 64'(pend_vec()));
    chk("commit_count", 64'(commit_count), 64'(cnt_m));
    @(posedge clk);
    if (pres_v) begin
      pend_m[pres_rd] = 1'b0;
      cnt_m++;
    end
    if (issue_valid && issue_rd != 0) pend_m[issue_rd] = 1'b1;
    if (flush) for (int i = 0; i < 32; i++) pend_m[i] = 1'b0;
    acc  = exp_lr || exp_ar;
    rd   = exp_lr ? wb_if.lsu_rd   : wb_if.alu_rd;
    data = exp_lr ? wb_if.lsu_data : wb_if.alu_data;
    pres_v  = acc && (rd != 0);
    pres_rd = rd;
    exp_q.push_back('{we: pres_v, rd: rd, data: data});
    alu_acc = exp_ar;
    lsu_acc = exp_lr;
    @(negedge clk);
  endtask

  // Monitor: every edge out of reset must present exactly the write the model predicted.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rf_write_en", 64'(rf_write_en == RF_WRITE), 64'(e.we));
        if (e.we) begin
          chk("rf_write_addr", 64'(rf_write_addr), 64'(e.rd));
          chk("rf_write_data", 64'(rf_write_data), 64'(e.data));
        end
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_wen"},    64'(rf_write_en == RF_WRITE), 64'd0);
    chk({tag, "_addr"},   64'(rf_write_addr), 64'd0);
    chk({tag, "_data"},   64'(rf_write_data), 64'd0);
    chk({tag, "_pend"},   64'(pending), 64'd0);
    chk({tag, "_count"},  64'(commit_count), 64'd0);
  endtask

  initial begin
    rst_n           = 1'b0;
    query_rs1       = '0;
    query_rs2       = '0;
    wb_if.alu_rd    = '0;
    wb_if.alu_data  = '0;
    wb_if.lsu_rd    = '0;
    wb_if.lsu_data  = '0;
    idle();
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    // ALU only: issue x5, then commit 0x1234 to x5 while decode queries x5.
    issue_valid = 1'b1; issue_rd = 5'd5;
    cycle();
    idle();
    wb_if.alu_valid = 1'b1; wb_if.alu_rd = 5'd5; wb_if.alu_data = 32'h1234;
    query_rs1 = 5'd5;
    cycle();
    idle();
    cycle();
    cycle();
    chk("alu_commit_count", 64'(commit_count), 64'd1);
    chk("alu_pend5_clear", 64'(pending[5]), 64'd0);

    // ALU and LSU together: LSU x4 first, held ALU x3 next.
    wb_if.alu_valid = 1'b1; wb_if.alu_rd = 5'd3; wb_if.alu_data = 32'hA3A3_0003;
    wb_if.lsu_valid = 1'b1; wb_if.lsu_rd = 5'd4; wb_if.lsu_data = 32'hB4B4_0004;
    cycle();
    wb_if.lsu_valid = 1'b0;
    cycle();
    idle();
    cycle();
    cycle();
    chk("dual_commit_count", 64'(commit_count), 64'd3);

    // x0 result: consumed, never written.
    wb_if.lsu_valid = 1'b1; wb_if.lsu_rd = 5'd0; wb_if.lsu_data = 32'hFFFF;
    cycle();
    idle();
    cycle();
    chk("x0_count", 64'(commit_count), 64'd3);

    // Same-edge issue and commit of x7: set wins.
    issue_valid = 1'b1; issue_rd = 5'd7;
    cycle();
    idle();
    wb_if.alu_valid = 1'b1; wb_if.alu_rd = 5'd7; wb_if.alu_data = 32'h7777;
    cycle();
    idle();
    issue_valid = 1'b1; issue_rd = 5'd7;
    cycle();
    idle();
    query_rs2 = 5'd7;
    cycle();
    chk("x7_still_pending", 64'(pending[7]), 64'd1);

    // Flush with x2/x9 pending, a registered write in flight and a blocked producer.
    issue_valid = 1'b1; issue_rd = 5'd2;
    cycle();
    issue_rd = 5'd9;
    wb_if.alu_valid = 1'b1; wb_if.alu_rd = 5'd9; wb_if.alu_data = 32'h9999;
    cycle();
    issue_rd = 5'd11; flush = 1'b1;
    wb_if.alu_valid = 1'b1; wb_if.alu_rd = 5'd12; wb_if.alu_data = 32'hC0C0;
    wb_if.lsu_valid = 1'b1; wb_if.lsu_rd = 5'd13; wb_if.lsu_data = 32'hD0D0;
    cycle();
    idle();
    cycle();
    chk("flush_pending", 64'(pending), 64'd0);

    // Reset while a write is registered.
    wb_if.alu_valid = 1'b1; wb_if.alu_rd = 5'd6; wb_if.alu_data = 32'h6666;
    issue_valid = 1'b1; issue_rd = 5'd6;
    cycle();
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    idle();
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cycle();

    // Randomized traffic; producers hold rd/data until accepted.
    for (int n = 0; n < 400; n++) begin
      if (!wb_if.alu_valid || alu_acc) begin
        wb_if.alu_valid = ($urandom_range(0, 2) != 0);
        wb_if.alu_rd    = 5'($urandom);
        wb_if.alu_data  = $urandom;
      end
      if (!wb_if.lsu_valid || lsu_acc) begin
        wb_if.lsu_valid = ($urandom_range(0, 3) == 0);
        wb_if.lsu_rd    = 5'($urandom);
        wb_if.lsu_data  = $urandom;
      end
      issue_valid = ($urandom_range(0, 1) == 1);
      issue_rd    = 5'($urandom);
      flush       = ($urandom_range(0, 15) == 0);
      query_rs1   = 5'($urandom);
      query_rs2   = 5'($urandom);
      cycle();
    end
    idle();
    cycle();
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
